// File: rtl/control_pipeline.sv
// Pipelined control path: D->E->M->W control/address registers, load-use and
// branch hazard resolution, E-stage forwarding selects and saturating stall/flush counters.
module control_pipeline #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  RegisterWrite_D,
  input  logic                  ALUSourceSelect_D,
  input  logic                  MemoryWrite_D,
  input  logic                  ResultSourceSelect_D,
  input  logic                  Branch_D,
  input  logic [2:0]            ALUcontrol_D,
  input  logic [REG_ADDR_W-1:0] rs1_D,
  input  logic [REG_ADDR_W-1:0] rs2_D,
  input  logic [REG_ADDR_W-1:0] rd_D,
  input  logic                  zero_E,
  output logic                  RegisterWrite_E,
  output logic                  ALUSourceSelect_E,
  output logic                  MemoryWrite_E,
  output logic                  ResultSourceSelect_E,
  output logic                  Branch_E,
  output logic [2:0]            ALUcontrol_E,
  output logic [REG_ADDR_W-1:0] rs1_E,
  output logic [REG_ADDR_W-1:0] rs2_E,
  output logic [REG_ADDR_W-1:0] rd_E,
  output logic                  RegisterWrite_M,
  output logic                  MemoryWrite_M,
  output logic                  ResultSourceSelect_M,
  output logic [REG_ADDR_W-1:0] rd_M,
  output logic                  RegisterWrite_W,
  output logic                  ResultSourceSelect_W,
  output logic [REG_ADDR_W-1:0] rd_W,
  output logic                  stall_F,
  output logic                  stall_D,
  output logic                  flush_D,
  output logic                  flush_E,
  output logic                  pcsrc_E,
  output logic [1:0]            forwardA_E,
  output logic [1:0]            forwardB_E,
  output logic [CNT_W-1:0]      stall_count,
  output logic [CNT_W-1:0]      flush_count
);

  typedef struct packed {
    logic                  rw;
    logic                  alusrc;
    logic                  mw;
    logic                  rs;
    logic                  br;
    logic [2:0]            alu;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
  } e_t;

  typedef struct packed {
    logic                  rw;
    logic                  mw;
    logic                  rs;
    logic [REG_ADDR_W-1:0] rd;
  } m_t;

  typedef struct packed {
    logic                  rw;
    logic                  rs;
    logic [REG_ADDR_W-1:0] rd;
  } w_t;

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  e_t               e_d, e_q;
  m_t               m_q;
  w_t               w_q;
  logic             lu;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_comb begin
    e_d        = '0;
    e_d.rw     = RegisterWrite_D;
    e_d.alusrc = ALUSourceSelect_D;
    e_d.mw     = MemoryWrite_D;
    e_d.rs     = ResultSourceSelect_D;
    e_d.br     = Branch_D;
    e_d.alu    = ALUcontrol_D;
    e_d.rs1    = rs1_D;
    e_d.rs2    = rs2_D;
    e_d.rd     = rd_D;
  end

  // A load in E whose destination a D source needs; x0 never hazards.
  assign lu      = e_q.rs & e_q.rw & (e_q.rd != '0) & ((e_q.rd == rs1_D) | (e_q.rd == rs2_D));
  assign pcsrc_E = e_q.br & zero_E;
  assign stall_D = lu & ~pcsrc_E;
  assign stall_F = stall_D;
  assign flush_D = pcsrc_E;
  assign flush_E = lu | pcsrc_E;

  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs, input m_t m, input w_t w);
    if (m.rw && (m.rd != '0) && (m.rd == rs))      return 2'b10;
    else if (w.rw && (w.rd != '0) && (w.rd == rs)) return 2'b01;
    else                                           return 2'b00;
  endfunction

  assign forwardA_E = fwd_sel(e_q.rs1, m_q, w_q);
  assign forwardB_E = fwd_sel(e_q.rs2, m_q, w_q);

  always_ff @(posedge clk) begin
    if (reset) begin
      e_q <= '0;
      m_q <= '0;
      w_q <= '0;
    end else begin
      e_q <= flush_E ? '0 : e_d;
      m_q <= '{rw: e_q.rw, mw: e_q.mw, rs: e_q.rs, rd: e_q.rd};
      w_q <= '{rw: m_q.rw, rs: m_q.rs, rd: m_q.rd};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (stall_D && (stall_cnt_q != CNT_MAX)) stall_cnt_q <= stall_cnt_q + CNT_ONE;
      if (flush_D && (flush_cnt_q != CNT_MAX)) flush_cnt_q <= flush_cnt_q + CNT_ONE;
    end
  end

  assign RegisterWrite_E      = e_q.rw;
  assign ALUSourceSelect_E    = e_q.alusrc;
  assign MemoryWrite_E        = e_q.mw;
  assign ResultSourceSelect_E = e_q.rs;
  assign Branch_E             = e_q.br;
  assign ALUcontrol_E         = e_q.alu;
  assign rs1_E                = e_q.rs1;
  assign rs2_E                = e_q.rs2;
  assign rd_E                 = e_q.rd;
  assign RegisterWrite_M      = m_q.rw;
  assign MemoryWrite_M        = m_q.mw;
  assign ResultSourceSelect_M = m_q.rs;
  assign rd_M                 = m_q.rd;
  assign RegisterWrite_W      = w_q.rw;
  assign ResultSourceSelect_W = w_q.rs;
  assign rd_W                 = w_q.rd;
  assign stall_count          = stall_cnt_q;
  assign flush_count          = flush_cnt_q;

endmodule

// File: tb/tb_control_pipeline.sv
// Bench for control_pipeline: instruction-history model compared every cycle,
// plus directed scenarios with literal expectations (CNT_W=4 to reach saturation).
module tb_control_pipeline;
  localparam int AW  = 5;
  localparam int CW  = 4;
  localparam int MAX = (1 << CW) - 1;

  typedef struct packed {
    logic          rw;
    logic          alusrc;
    logic          mw;
    logic          rs;
    logic          br;
    logic [2:0]    alu;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic [AW-1:0] rd;
  } instr_t;

  logic clk, reset, zero_E;
  instr_t din;
  logic RegisterWrite_E, ALUSourceSelect_E, MemoryWrite_E, ResultSourceSelect_E, Branch_E;
  logic [2:0] ALUcontrol_E;
  logic [AW-1:0] rs1_E, rs2_E, rd_E, rd_M, rd_W;
  logic RegisterWrite_M, MemoryWrite_M, ResultSourceSelect_M, RegisterWrite_W, ResultSourceSelect_W;
  logic stall_F, stall_D, flush_D, flush_E, pcsrc_E;
  logic [1:0] forwardA_E, forwardB_E;
  logic [CW-1:0] stall_count, flush_count;

  int n_tests = 0;
  int n_fail  = 0;

  control_pipeline #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .RegisterWrite_D(din.rw), .ALUSourceSelect_D(din.alusrc), .MemoryWrite_D(din.mw),
    .ResultSourceSelect_D(din.rs), .Branch_D(din.br), .ALUcontrol_D(din.alu),
    .rs1_D(din.rs1), .rs2_D(din.rs2), .rd_D(din.rd), .zero_E(zero_E),
    .RegisterWrite_E(RegisterWrite_E), .ALUSourceSelect_E(ALUSourceSelect_E),
    .MemoryWrite_E(MemoryWrite_E), .ResultSourceSelect_E(ResultSourceSelect_E),
    .Branch_E(Branch_E), .ALUcontrol_E(ALUcontrol_E),
    .rs1_E(rs1_E), .rs2_E(rs2_E), .rd_E(rd_E),
    .RegisterWrite_M(RegisterWrite_M), .MemoryWrite_M(MemoryWrite_M),
    .ResultSourceSelect_M(ResultSourceSelect_M), .rd_M(rd_M),
    .RegisterWrite_W(RegisterWrite_W), .ResultSourceSelect_W(ResultSourceSelect_W), .rd_W(rd_W),
    .stall_F(stall_F), .stall_D(stall_D), .flush_D(flush_D), .flush_E(flush_E), .pcsrc_E(pcsrc_E),
    .forwardA_E(forwardA_E), .forwardB_E(forwardB_E),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: the pipeline is the last three instructions accepted into E, oldest in W.
  instr_t mE, mM, mW;
  int     msc, mfc;
  logic   started = 1'b0;

  function automatic logic m_lu();
    return mE.rs && mE.rw && (mE.rd != 0) && (mE.rd == din.rs1 || mE.rd == din.rs2);
  endfunction

  function automatic logic m_pc();
    return mE.br && zero_E;
  endfunction

  function automatic logic [1:0] m_fwd(input logic [AW-1:0] src);
    if (mM.rw && mM.rd != 0 && mM.rd == src) return 2'd2;
    if (mW.rw && mW.rd != 0 && mW.rd == src) return 2'd1;
    return 2'd0;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      mE <= '0; mM <= '0; mW <= '0; msc <= 0; mfc <= 0; started <= 1'b1;
    end else if (started) begin
      if (m_lu() && !m_pc() && msc < MAX) msc <= msc + 1;
      if (m_pc() && mfc < MAX) mfc <= mfc + 1;
      mW <= mM;
      mM <= mE;
      mE <= (m_lu() || m_pc()) ? '0 : din;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("E_ctrl", {RegisterWrite_E, ALUSourceSelect_E, MemoryWrite_E, ResultSourceSelect_E, Branch_E, ALUcontrol_E},
          {mE.rw, mE.alusrc, mE.mw, mE.rs, mE.br, mE.alu});
      chk("E_addr", {rs1_E, rs2_E, rd_E}, {mE.rs1, mE.rs2, mE.rd});
      chk("M_stage", {RegisterWrite_M, MemoryWrite_M, ResultSourceSelect_M, rd_M}, {mM.rw, mM.mw, mM.rs, mM.rd});
      chk("W_stage", {RegisterWrite_W, ResultSourceSelect_W, rd_W}, {mW.rw, mW.rs, mW.rd});
      chk("pcsrc_E", pcsrc_E, m_pc());
      chk("stall_F", stall_F, m_lu() && !m_pc());
      chk("stall_D", stall_D, m_lu() && !m_pc());
      chk("flush_D", flush_D, m_pc());
      chk("flush_E", flush_E, m_lu() || m_pc());
      chk("forwardA_E", forwardA_E, m_fwd(mE.rs1));
      chk("forwardB_E", forwardB_E, m_fwd(mE.rs2));
      chk("stall_count", stall_count, msc);
      chk("flush_count", flush_count, mfc);
    end
  end

  function automatic instr_t mk(input logic rw, input logic alusrc, input logic mw, input logic rs,
                                input logic br, input logic [2:0] alu,
                                input logic [AW-1:0] rs1, input logic [AW-1:0] rs2, input logic [AW-1:0] rd);
    instr_t t;
    t = '{rw: rw, alusrc: alusrc, mw: mw, rs: rs, br: br, alu: alu, rs1: rs1, rs2: rs2, rd: rd};
    return t;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  instr_t tbl [16];
  logic [15:0] zpat = 16'b0010_0100_1000_1001;

  initial begin
    reset = 1'b1; zero_E = 1'b0; din = '0;
    step(); step();
    #1;
    chk("rst_RW_E", RegisterWrite_E, 0);
    chk("rst_RW_W", RegisterWrite_W, 0);
    chk("rst_fwdA", forwardA_E, 0);
    chk("rst_stall", stall_D, 0);
    chk("rst_cnt", {stall_count, flush_count}, 0);
    reset = 1'b0;

    // load-use: lw x5 then a consumer of x5
    din = mk(1, 1, 0, 1, 0, 3'd0, 5'd1, 5'd0, 5'd5);
    step();
    din = mk(1, 0, 0, 0, 0, 3'd2, 5'd5, 5'd6, 5'd7);
    #1;
    chk("lu_stall_F", stall_F, 1);
    chk("lu_stall_D", stall_D, 1);
    chk("lu_flush_E", flush_E, 1);
    chk("lu_flush_D", flush_D, 0);
    step(); #1;
    chk("lu_bubble_RW_E", RegisterWrite_E, 0);
    chk("lu_stall_count", stall_count, 1);
    chk("lu_one_cycle", stall_D, 0);
    step(); #1;
    chk("lu_fwd_from_W", forwardA_E, 2'b01);

    // forwarding priority
    din = mk(1, 0, 0, 0, 0, 3'd0, 5'd1, 5'd2, 5'd3);
    step(); step();
    din = mk(1, 0, 0, 0, 0, 3'd0, 5'd3, 5'd3, 5'd8);
    step(); #1;
    chk("fwdA_M_prio", forwardA_E, 2'b10);
    chk("fwdB_M_prio", forwardB_E, 2'b10);
    din = mk(1, 0, 0, 0, 0, 3'd0, 5'd1, 5'd2, 5'd3);
    step();
    din = mk(0, 0, 0, 0, 0, 3'd0, 5'd1, 5'd2, 5'd3);
    step();
    din = mk(1, 0, 0, 0, 0, 3'd0, 5'd3, 5'd3, 5'd8);
    step(); #1;
    chk("fwdA_W_only", forwardA_E, 2'b01);
    din = mk(1, 0, 0, 0, 0, 3'd0, 5'd1, 5'd2, 5'd0);
    step(); step();
    din = mk(1, 0, 0, 0, 0, 3'd0, 5'd0, 5'd0, 5'd8);
    step(); #1;
    chk("fwdA_x0", forwardA_E, 2'b00);
    chk("fwdB_x0", forwardB_E, 2'b00);

    // taken branch
    reset = 1'b1; step(); reset = 1'b0;
    din = mk(0, 0, 0, 0, 1, 3'd1, 5'd1, 5'd2, 5'd0);
    step();
    din = mk(1, 1, 1, 0, 0, 3'd4, 5'd4, 5'd5, 5'd9);
    zero_E = 1'b1;
    #1;
    chk("br_pcsrc", pcsrc_E, 1);
    chk("br_flush_D", flush_D, 1);
    chk("br_flush_E", flush_E, 1);
    chk("br_no_stall", stall_F, 0);
    step(); zero_E = 1'b0; #1;
    chk("br_E_zero", {RegisterWrite_E, ALUSourceSelect_E, MemoryWrite_E, Branch_E, ALUcontrol_E, rs1_E, rs2_E, rd_E}, 0);
    chk("br_flush_count", flush_count, 1);

    // load-use and taken branch together: branch wins
    din = mk(1, 0, 0, 1, 1, 3'd0, 5'd1, 5'd2, 5'd7);
    step();
    din = mk(1, 0, 0, 0, 0, 3'd0, 5'd7, 5'd1, 5'd8);
    zero_E = 1'b1;
    #1;
    chk("both_stall_F", stall_F, 0);
    chk("both_flush_D", flush_D, 1);
    chk("both_flush_E", flush_E, 1);
    step(); zero_E = 1'b0; #1;
    chk("both_stall_count", stall_count, 0);
    chk("both_flush_count", flush_count, 2);

    // mixed traffic, checked by the model only
    tbl[0]  = mk(1, 1, 0, 1, 0, 3'd0, 5'd1, 5'd0, 5'd2);
    tbl[1]  = mk(1, 0, 0, 0, 0, 3'd2, 5'd3, 5'd2, 5'd1);
    tbl[2]  = mk(0, 1, 1, 0, 0, 3'd0, 5'd1, 5'd2, 5'd0);
    tbl[3]  = mk(0, 0, 0, 0, 1, 3'd1, 5'd1, 5'd3, 5'd0);
    tbl[4]  = mk(1, 0, 0, 0, 0, 3'd3, 5'd2, 5'd1, 5'd3);
    tbl[5]  = mk(1, 1, 0, 1, 0, 3'd0, 5'd3, 5'd0, 5'd0);
    tbl[6]  = mk(1, 0, 0, 0, 0, 3'd5, 5'd0, 5'd0, 5'd2);
    tbl[7]  = mk(1, 1, 0, 1, 0, 3'd0, 5'd2, 5'd0, 5'd3);
    tbl[8]  = mk(0, 1, 1, 0, 0, 3'd0, 5'd1, 5'd3, 5'd0);
    tbl[9]  = mk(0, 0, 0, 0, 1, 3'd1, 5'd3, 5'd2, 5'd0);
    tbl[10] = mk(1, 0, 0, 0, 0, 3'd6, 5'd3, 5'd3, 5'd1);
    tbl[11] = mk(1, 1, 0, 1, 1, 3'd0, 5'd1, 5'd0, 5'd2);
    tbl[12] = mk(1, 0, 0, 0, 0, 3'd7, 5'd2, 5'd1, 5'd31);
    tbl[13] = mk(1, 0, 0, 0, 0, 3'd2, 5'd31, 5'd2, 5'd1);
    tbl[14] = mk(0, 0, 0, 0, 1, 3'd1, 5'd1, 5'd31, 5'd0);
    tbl[15] = mk(0, 0, 0, 0, 0, 3'd0, 5'd0, 5'd0, 5'd0);
    for (int i = 0; i < 16; i++) begin
      din = tbl[i];
      zero_E = zpat[i];
      step();
    end
    zero_E = 1'b0;

    // saturation: one stall per lw/use pair, 20 pairs
    reset = 1'b1; step(); reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      din = mk(1, 1, 0, 1, 0, 3'd0, 5'd1, 5'd0, 5'd5);
      step();
      din = mk(1, 0, 0, 0, 0, 3'd0, 5'd5, 5'd2, 5'd6);
      step();
    end
    #1;
    chk("sat_stall_count", stall_count, 15);

    // reset with a full pipeline, then refill
    din = mk(1, 0, 1, 1, 0, 3'd2, 5'd1, 5'd2, 5'd4);
    step(); step(); step();
    reset = 1'b1; step(); reset = 1'b0; #1;
    chk("mrst_RW", {RegisterWrite_E, RegisterWrite_M, RegisterWrite_W}, 0);
    chk("mrst_rd", {rd_E, rd_M, rd_W}, 0);
    chk("mrst_cnt", {stall_count, flush_count}, 0);
    step(); step(); #1;
    chk("refill_M", {RegisterWrite_M, RegisterWrite_W}, 2'b10);
    step(); #1;
    chk("refill_W", {RegisterWrite_W, rd_W}, {1'b1, 5'd4});

    step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
